uart_rx_capture: RTL and testbench

- Parametrised, synthesizable UART receiver with a 16× oversampling front end and a character FIFO.
- Runtime-configurable frame format: data bits, parity and stop bits.
- Flags framing, parity and overrun errors per character or as sticky bits.
- Sits in the verification and debug path, on any UART TX pin of the SoC (UART0/UART1 pads), and replaces the untimed behavioural serial terminal.
- A bench or on-chip logger pops received characters through a ready/valid port.

---
 rtl/uart_rx_pkg.sv | 33 +++
 rtl/uart_rx_fifo.sv | 51 +++++
 rtl/uart_rx_capture.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_capture.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the uart_rx_capture receiver.
// Holds the FSM encoding, parity-mode codes and the FIFO entry layout.
package uart_rx_pkg;

  localparam int OVS = 16;
  localparam logic [3:0] MID_SAMPLE = 4'd7;
  localparam logic [3:0] LAST_TICK  = 4'(OVS - 1);

  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_EVEN = 2'd1;
  localparam logic [1:0] PAR_ODD  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  typedef struct packed {
    logic       perr;
    logic       ferr;
    logic [7:0] data;
  } uart_rx_entry_t;

  // Mode 3 is reserved and behaves like no parity.
  function automatic logic parity_enabled(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Generic synchronous FIFO with pointers one bit wider than the address.
// The head entry is presented combinationally and forced to zero when empty.
module uart_rx_fifo #(
  parameter int  DEPTH   = 16,
  parameter type entry_t = logic [7:0]
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  entry_t                   push_data,
  output logic                     full,
  input  logic                     pop,
  output entry_t                   head,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign level   = wptr - rptr;
  assign empty   = (wptr == rptr);
  // Occupancy never exceeds DEPTH, so its MSB alone marks full.
  assign full    = level[AW];
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    head = '0;
    if (!empty) head = mem[rptr[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_rx_capture.sv
// 16x oversampling UART receiver feeding a character FIFO with per-character
// framing/parity flags and a sticky overrun bit; used to capture SoC UART TX pins.
module uart_rx_capture
  import uart_rx_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_W      = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx,
  input  logic [DIV_W-1:0]              baud_div,
  input  logic [1:0]                    data_bits,
  input  logic [1:0]                    parity_mode,
  input  logic                          two_stop,
  output logic [7:0]                    rd_data,
  output logic                          rd_ferr,
  output logic                          rd_perr,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic                          overrun,
  input  logic                          clr_err,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output state_t                        dbg_state
);

  logic rx_meta, rxs, rxs_d, fall;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      rxs_d   <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      rxs_d   <= rxs;
    end
  end

  assign fall = rxs_d & ~rxs;

  logic [DIV_W-1:0] tick_cnt;
  logic             tick;
  logic             restart;

  assign tick = (tick_cnt == '0);

  // Zero after reset behaves as an immediate reload: the next clock loads baud_div.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                tick_cnt <= '0;
    else if (restart || tick)    tick_cnt <= baud_div;
    else                         tick_cnt <= tick_cnt - 1'b1;
  end

  state_t         state, state_n;
  logic [3:0]     tc, tc_n;
  logic [2:0]     bc, bc_n;
  logic           sb, sb_n;
  logic [7:0]     shreg, shreg_n;
  logic           perr, perr_n;
  logic           ferr, ferr_n;
  logic [1:0]     cfg_bits, cfg_bits_n;
  logic [1:0]     cfg_par, cfg_par_n;
  logic           cfg_two, cfg_two_n;
  logic           push_q, push_n;
  uart_rx_entry_t entry_q, entry_n;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= ST_IDLE;
      tc       <= '0;
      bc       <= '0;
      sb       <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
      cfg_bits <= '0;
      cfg_par  <= PAR_NONE;
      cfg_two  <= 1'b0;
      push_q   <= 1'b0;
      entry_q  <= '0;
    end else begin
      state    <= state_n;
      tc       <= tc_n;
      bc       <= bc_n;
      sb       <= sb_n;
      shreg    <= shreg_n;
      perr     <= perr_n;
      ferr     <= ferr_n;
      cfg_bits <= cfg_bits_n;
      cfg_par  <= cfg_par_n;
      cfg_two  <= cfg_two_n;
      push_q   <= push_n;
      entry_q  <= entry_n;
    end
  end

  always_comb begin
    state_n    = state;
    tc_n       = tc;
    bc_n       = bc;
    sb_n       = sb;
    shreg_n    = shreg;
    perr_n     = perr;
    ferr_n     = ferr;
    cfg_bits_n = cfg_bits;
    cfg_par_n  = cfg_par;
    cfg_two_n  = cfg_two;
    push_n     = 1'b0;
    entry_n    = entry_q;
    restart    = 1'b0;

    case (state)
      ST_IDLE: begin
        if (fall) begin
          state_n = ST_START;
          tc_n    = '0;
          restart = 1'b1;
        end
      end
      ST_START: begin
        if (tick) begin
          if (tc == MID_SAMPLE) begin
            if (rxs) begin
              state_n = ST_IDLE;
            end else begin
              // Restarting tc here puts every later sample at a bit mid-point.
              state_n    = ST_DATA;
              tc_n       = '0;
              bc_n       = '0;
              sb_n       = 1'b0;
              shreg_n    = '0;
              perr_n     = 1'b0;
              ferr_n     = 1'b0;
              cfg_bits_n = data_bits;
              cfg_par_n  = parity_mode;
              cfg_two_n  = two_stop;
            end
          end else begin
            tc_n = tc + 4'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          tc_n = tc + 4'd1;
          if (tc == LAST_TICK) begin
            shreg_n[bc] = rxs;
            bc_n        = bc + 3'd1;
            if (bc == 3'(cfg_bits) + 3'd4)
              state_n = parity_enabled(cfg_par) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (tick) begin
          tc_n = tc + 4'd1;
          if (tc == LAST_TICK) begin
            perr_n  = rxs ^ (^shreg) ^ (cfg_par == PAR_ODD);
            state_n = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          tc_n = tc + 4'd1;
          if (tc == LAST_TICK) begin
            if (!rxs) ferr_n = 1'b1;
            if (cfg_two && !sb) begin
              sb_n = 1'b1;
            end else begin
              push_n       = 1'b1;
              entry_n.perr = perr;
              entry_n.ferr = ferr | ~rxs;
              entry_n.data = shreg;
              // A low final stop bit may be a break: hold off until the line idles.
              state_n      = rxs ? ST_IDLE : ST_WAIT_IDLE;
            end
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (rxs) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign dbg_state = state;

  uart_rx_entry_t head;
  logic           fifo_full;
  logic           fifo_empty;

  uart_rx_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (uart_rx_entry_t)
  ) u_fifo (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .push      (push_q),
    .push_data (entry_q),
    .full      (fifo_full),
    .pop       (rd_ready),
    .head      (head),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign rd_data  = head.data;
  assign rd_ferr  = head.ferr;
  assign rd_perr  = head.perr;
  assign rd_valid = ~fifo_empty;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)                                 overrun <= 1'b0;
    else if (clr_err)                             overrun <= 1'b0;
    else if (push_q && fifo_full && !rd_ready)    overrun <= 1'b1;
  end

endmodule

// File: tb/tb_uart_rx_capture.sv
// Directed bench for uart_rx_capture: a vector table of frame formats plus
// hand-written glitch, break, overflow and mid-frame reset sequences.
module tb_uart_rx_capture;
  import uart_rx_pkg::*;

  // Read/write handshake: an entry leaves the FIFO on a clock edge where rd_valid & rd_ready.
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx = 1'b1;
  logic [15:0] baud_div = 16'd0;
  logic [1:0]  data_bits = 2'd3;
  logic [1:0]  parity_mode = 2'd0;
  logic        two_stop = 1'b0;
  logic        rd_ready = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  rd_data;
  logic        rd_ferr, rd_perr, rd_valid, overrun;
  logic [4:0]  level;
  state_t      dbg_state;

  int checks = 0;
  int failures = 0;
  int lat = 0;
  logic [9:0] exp_q[$];

  typedef struct {
    logic [1:0]  db;
    logic [1:0]  pm;
    logic        ts;
    logic [15:0] div;
    logic [7:0]  ch;
    logic        bad_par;
    logic [1:0]  stops;
    logic [9:0]  exp;
  } vec_t;

  localparam int NV = 12;
  vec_t vecs[NV];

  uart_rx_capture #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .rx          (rx),
    .baud_div    (baud_div),
    .data_bits   (data_bits),
    .parity_mode (parity_mode),
    .two_stop    (two_stop),
    .rd_data     (rd_data),
    .rd_ferr     (rd_ferr),
    .rd_perr     (rd_perr),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .overrun     (overrun),
    .clr_err     (clr_err),
    .level       (level),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #900us;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Driver tasks
  task automatic align();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b, input int n);
    rx = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // par: 1 even, 2 odd, anything else sends no parity bit
  task automatic send_frame(input logic [7:0] ch, input int nbits, input int par,
                            input logic bad_par, input int nstop, input logic [1:0] stops,
                            input int bitclk);
    logic p;
    drive_bit(1'b0, bitclk);
    for (int i = 0; i < nbits; i++) drive_bit(ch[i], bitclk);
    if (par == 1 || par == 2) begin
      p = 1'b0;
      for (int i = 0; i < nbits; i++) p = p ^ ch[i];
      if (par == 2) p = ~p;
      drive_bit(p ^ bad_par, bitclk);
    end
    for (int i = 0; i < nstop; i++) drive_bit(stops[i], bitclk);
    rx = 1'b1;
  endtask

  // Scoreboard helpers
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [9:0] exp);
    int n = 0;
    @(negedge clk);
    while (!rd_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, rd_valid, 1);
    check(name, {rd_perr, rd_ferr, rd_data}, exp);
    rd_ready = 1'b1;
    @(posedge clk);
    #1 rd_ready = 1'b0;
  endtask

  task automatic set_8n1();
    baud_div = 16'd0; data_bits = 2'd3; parity_mode = 2'd0; two_stop = 1'b0;
  endtask

  initial begin
    logic [7:0] ch;

    //                db    pm    ts    div    ch     bad   stops  {perr,ferr,data}
    vecs[0]  = '{2'd3, 2'd0, 1'b0, 16'd0, 8'h55, 1'b0, 2'b11, 10'h055};
    vecs[1]  = '{2'd3, 2'd0, 1'b0, 16'd0, 8'hA3, 1'b0, 2'b11, 10'h0A3};
    vecs[2]  = '{2'd2, 2'd1, 1'b0, 16'd0, 8'h41, 1'b0, 2'b11, 10'h041};
    vecs[3]  = '{2'd2, 2'd1, 1'b0, 16'd0, 8'h43, 1'b1, 2'b11, 10'h243};
    vecs[4]  = '{2'd3, 2'd1, 1'b1, 16'd4, 8'hA5, 1'b0, 2'b01, 10'h1A5};
    vecs[5]  = '{2'd0, 2'd2, 1'b0, 16'd0, 8'h1B, 1'b0, 2'b11, 10'h01B};
    vecs[6]  = '{2'd1, 2'd0, 1'b0, 16'd0, 8'hFF, 1'b0, 2'b11, 10'h03F};
    vecs[7]  = '{2'd3, 2'd0, 1'b0, 16'd0, 8'h0F, 1'b0, 2'b00, 10'h10F};
    vecs[8]  = '{2'd3, 2'd2, 1'b0, 16'd1, 8'h80, 1'b0, 2'b11, 10'h080};
    vecs[9]  = '{2'd3, 2'd3, 1'b0, 16'd0, 8'h3C, 1'b0, 2'b11, 10'h03C};
    vecs[10] = '{2'd3, 2'd1, 1'b1, 16'd4, 8'h5A, 1'b0, 2'b11, 10'h05A};
    vecs[11] = '{2'd3, 2'd2, 1'b0, 16'd0, 8'h00, 1'b1, 2'b00, 10'h300};

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_valid", rd_valid, 0);
    check("rst_level", level, 0);
    check("rst_head", {rd_perr, rd_ferr, rd_data}, 0);
    check("rst_overrun", overrun, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // Basic receive with latency measurement from the start edge
    set_8n1();
    align();
    fork
      send_frame(8'h55, 8, 0, 1'b0, 1, 2'b11, 16);
      begin
        lat = 0;
        do begin
          @(posedge clk);
          lat++;
          @(negedge clk);
        end while (!rd_valid && lat < 400);
      end
    join
    checks++;
    if (!(lat >= 150 && lat <= 170)) begin
      failures++;
      $display("FAIL latency actual=%0d required=150..170", lat);
    end
    pop_check("basic_55", 10'h055);
    idle(20);

    // Frame-format vector table
    for (int k = 0; k < NV; k++) begin
      baud_div    = vecs[k].div;
      data_bits   = vecs[k].db;
      parity_mode = vecs[k].pm;
      two_stop    = vecs[k].ts;
      align();
      send_frame(vecs[k].ch, int'(vecs[k].db) + 5, int'(vecs[k].pm), vecs[k].bad_par,
                 vecs[k].ts ? 2 : 1, vecs[k].stops, 16 * (int'(vecs[k].div) + 1));
      pop_check($sformatf("vec%0d", k), vecs[k].exp);
      idle(20);
    end

    // Glitch: a 5-clock low pulse is rejected at the start mid-point
    set_8n1();
    align();
    rx = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("glitch_detected", dbg_state, ST_START);
    rx = 1'b1;
    idle(40);
    @(negedge clk);
    check("glitch_state", dbg_state, ST_IDLE);
    check("glitch_level", level, 0);

    // Break: 400 low clocks give exactly one 0x00 entry with ferr
    align();
    rx = 1'b0;
    repeat (400) @(posedge clk);
    @(negedge clk);
    check("break_level", level, 1);
    check("break_wait", dbg_state, ST_WAIT_IDLE);
    rx = 1'b1;
    idle(40);
    @(negedge clk);
    check("break_level_after", level, 1);
    check("break_idle", dbg_state, ST_IDLE);
    pop_check("break_entry", 10'h100);
    idle(20);

    // Overflow: 17 characters into a 16-entry FIFO
    align();
    for (int i = 0; i < 17; i++) begin
      ch = 8'(8'h30 + i * 3);
      send_frame(ch, 8, 0, 1'b0, 1, 2'b11, 16);
      if (i < 16) exp_q.push_back({2'b00, ch});
    end
    idle(20);
    @(negedge clk);
    check("ovf_level", level, 16);
    check("ovf_overrun", overrun, 1);
    clr_err = 1'b1;
    @(posedge clk);
    #1 clr_err = 1'b0;
    @(negedge clk);
    check("clr_overrun", overrun, 0);

    // Push coincident with a pop at full, timed from the measured latency
    align();
    fork
      send_frame(8'hE7, 8, 0, 1'b0, 1, 2'b11, 16);
      begin
        repeat (lat - 1) @(posedge clk);
        @(negedge clk);
        check("coinc_head", {rd_perr, rd_ferr, rd_data}, exp_q.pop_front());
        rd_ready = 1'b1;
        @(posedge clk);
        #1 rd_ready = 1'b0;
      end
    join
    exp_q.push_back(10'h0E7);
    idle(10);
    @(negedge clk);
    check("coinc_level", level, 16);
    check("coinc_overrun", overrun, 0);
    while (exp_q.size() > 0) pop_check("drain", exp_q.pop_front());
    @(negedge clk);
    check("drain_level", level, 0);
    idle(20);

    // Reset mid-frame discards the partial character and empties the FIFO
    align();
    send_frame(8'h11, 8, 0, 1'b0, 1, 2'b11, 16);
    idle(10);
    rx = 1'b0;
    repeat (60) @(posedge clk);
    @(negedge clk);
    check("pre_rst_level", level, 1);
    check("pre_rst_state", dbg_state, ST_DATA);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_level", level, 0);
    check("mid_rst_head", {rd_perr, rd_ferr, rd_data}, 0);
    check("mid_rst_overrun", overrun, 0);
    check("mid_rst_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    idle(20);
    send_frame(8'hC6, 8, 0, 1'b0, 1, 2'b11, 16);
    pop_check("post_rst", 10'h0C6);
    @(negedge clk);
    check("post_rst_level", level, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
